// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the sram_ctrl initiator.
package sram_ctrl_pkg;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_e;

  // Credit counter must hold 0..depth inclusive.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Generic synchronous circular-buffer FIFO with occupancy output.
// Read data comes from storage only; a push into an empty FIFO is visible next cycle.
module sram_ctrl_rsp_fifo #(
  parameter  int unsigned WIDTH = 65,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (count_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready initiator for a single-port SRAM with in-order buffered responses.
// Define SRAM_CTRL_ZEROIZE_EN to clear the array after reset before accepting requests.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 64,
  parameter  int unsigned NUM_WORDS  = 1024,
  parameter  int unsigned RSP_DEPTH  = 4,
  localparam int unsigned AW         = $clog2(NUM_WORDS),
  localparam int unsigned BW         = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  init_done_o
);

  localparam int unsigned CW = credit_width(RSP_DEPTH);

  typedef struct packed {
    logic                  we;
    logic [DATA_WIDTH-1:0] rdata;
  } rsp_t;

  ctrl_state_e   state_q;
  logic          inflight_q, inflight_we_q;
  logic          accept;
  logic [CW-1:0] fifo_cnt, credit_cnt;
  logic          fifo_valid;
  rsp_t          push_data, pop_data;

`ifdef SRAM_CTRL_ZEROIZE_EN
  ctrl_state_e   state_d;
  logic [AW-1:0] zero_addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      zero_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) zero_addr_q <= zero_addr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && zero_addr_q == AW'(NUM_WORDS - 1)) state_d = RUN;
  end
`else
  assign state_q = RUN;
`endif

  assign init_done_o = (state_q == RUN);

  // Credits use registered state only, so a pop frees a slot one cycle later.
  assign credit_cnt  = fifo_cnt + CW'(inflight_q);
  assign req_ready_o = (state_q == RUN) && (credit_cnt < CW'(RSP_DEPTH));
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
    end else begin
      inflight_q <= accept;
      if (accept) inflight_we_q <= req_we_i;
    end
  end

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
`ifdef SRAM_CTRL_ZEROIZE_EN
    // Sweep strobes are gated by rst_ni so the port stays idle while reset is held.
    if (state_q == INIT) begin
      sram_req_o  = rst_ni;
      sram_we_o   = rst_ni;
      sram_addr_o = zero_addr_q;
      sram_be_o   = {BW{rst_ni}};
    end else
`endif
    if (accept) begin
      sram_req_o   = 1'b1;
      sram_we_o    = req_we_i;
      sram_addr_o  = req_addr_i;
      sram_wdata_o = req_wdata_i;
      sram_be_o    = req_be_i;
    end
  end

  assign push_data.we    = inflight_we_q;
  assign push_data.rdata = inflight_we_q ? '0 : sram_rdata_i;

  sram_ctrl_rsp_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (inflight_q),
    .wdata_i(push_data),
    .pop_i  (rsp_ready_i),
    .rdata_o(pop_data),
    .valid_o(fifo_valid),
    .count_o(fifo_cnt)
  );

  assign rsp_valid_o = fifo_valid;
  assign rsp_we_o    = fifo_valid && pop_data.we;
  assign rsp_rdata_o = fifo_valid ? pop_data.rdata : '0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized self-checking bench for sram_ctrl with a behavioural SRAM and reference model.
module tb_sram_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned NW = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned BW = 8;
`ifdef SRAM_CTRL_ZEROIZE_EN
  localparam logic ZEROIZE = 1'b1;
`else
  localparam logic ZEROIZE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [BW-1:0] sram_be;
  logic [DW-1:0] sram_rdata;
  logic          init_done;

  always #5 clk = ~clk;

  sram_ctrl #(
    .DATA_WIDTH(DW),
    .NUM_WORDS (NW),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_we_o    (rsp_we),
    .rsp_rdata_o (rsp_rdata),
    .sram_req_o  (sram_req),
    .sram_we_o   (sram_we),
    .sram_addr_o (sram_addr),
    .sram_wdata_o(sram_wdata),
    .sram_be_o   (sram_be),
    .sram_rdata_i(sram_rdata),
    .init_done_o (init_done)
  );

  // Behavioural single-port SRAM: byte-enabled writes, one-cycle read latency.
  logic [DW-1:0] sram_mem [NW];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < int'(BW); b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model: word memory updated at acceptance, plus a queue of expected responses.
  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  logic [DW-1:0] ref_mem [NW];
  exp_t          exp_q[$];
  int            cyc = 0;
  int            n_acc = 0;
  int            n_pops = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_we = 1'b0;
  logic [DW-1:0] prev_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      if (ZEROIZE) for (int i = 0; i < int'(NW); i++) ref_mem[i] = '0;
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_we", 64'(rsp_we), 64'(prev_we));
        check("hold_rdata", rsp_rdata, prev_rdata);
      end
      if (rsp_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() == 0) check("spurious_rsp", 64'd0, 64'd1);
          else check("rsp_latency", 64'(cyc - exp_q[0].cyc), 64'd2);
        end
        if (rsp_ready && exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_we", 64'(rsp_we), 64'(e.we));
          check("rsp_rdata", rsp_rdata, e.rdata);
          last_rdata = rsp_rdata;
          n_pops++;
        end
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e.we    = req_we;
        e.rdata = req_we ? '0 : ref_mem[req_addr];
        e.cyc   = cyc;
        exp_q.push_back(e);
        if (req_we)
          for (int b = 0; b < int'(BW); b++)
            if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        n_acc++;
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_we    = rsp_we;
      prev_rdata = rsp_rdata;
    end
  end

  task automatic do_req(input logic we, input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic got;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(a);
    req_wdata = d;
    req_be    = be;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("req_accept", 64'(got), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_sweep();
    for (int k = 0; k < int'(NW); k++) begin
      @(negedge clk);
      check("sweep_addr", 64'(sram_addr), 64'(k));
      check("sweep_wr", 64'({sram_req, sram_we, sram_be}), 64'({2'b11, {BW{1'b1}}}));
      check("sweep_busy", 64'({init_done, req_ready}), 64'd0);
    end
    @(negedge clk);
    check("init_done", 64'(init_done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int hold);
    rst_ni = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", {63'd0, rsp_we} | rsp_rdata, 64'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    int acc0, pops0;
    rst_ni    = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp", 64'({rsp_valid, rsp_we}), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_sram_ctl", 64'({sram_req, sram_we, sram_addr, sram_be}), 64'd0);
    check("rst_sram_wdata", sram_wdata, 64'd0);
    check("rst_init_done", 64'(init_done), 64'(!ZEROIZE));
    rst_ni = 1'b1;

    if (ZEROIZE) begin
      check_sweep();
      // Interrupt a sweep at address 8 and confirm it restarts from 0.
      pulse_reset(2);
      repeat (8) @(posedge clk);
      #1;
      check("sweep_mid_addr", 64'(sram_addr), 64'd8);
      pulse_reset(2);
      check_sweep();
      for (int a = 0; a < int'(NW); a++) do_req(1'b0, a, '0, '0);
      wait_idle();
      check("zero_rd", last_rdata, 64'd0);
    end else begin
      @(negedge clk);
      check("run_ready", 64'({init_done, req_ready}), 64'd3);
      @(posedge clk);
      #1;
    end

    for (int a = 0; a < int'(NW); a++) do_req(1'b1, a, {$urandom, $urandom}, '1);
    wait_idle();

    do_req(1'b1, 5, 64'hDEAD_BEEF, '1);
    do_req(1'b0, 5, '0, '0);
    wait_idle();
    check("rd5", last_rdata, 64'h0000_0000_DEAD_BEEF);
    do_req(1'b1, 7, '1, '1);
    do_req(1'b1, 7, '0, 8'h0F);
    do_req(1'b0, 7, '0, '0);
    wait_idle();
    check("rd7", last_rdata, 64'hFFFF_FFFF_0000_0000);

    // Back-to-back reads: 16 accepts in 16 cycles, 16 pops two cycles later with no gaps.
    acc0 = n_acc;
    pops0 = n_pops;
    req_valid = 1'b1;
    req_we = 1'b0;
    for (int a = 0; a < int'(NW); a++) begin
      req_addr = AW'(a);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("b2b_accepts", 64'(n_acc - acc0), 64'd16);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_pops", 64'(n_pops - pops0), 64'd16);
    wait_idle();

    // Stall: no pops, continuous requests.
    acc0 = n_acc;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr = AW'($urandom_range(0, NW - 1));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    check("stall_accepts", 64'(n_acc - acc0), 64'(DEPTH));
    check("stall_ready", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ready_pre_pop", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_post_pop", 64'(req_ready), 64'd1);
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) != 0;
      req_addr  = AW'($urandom_range(0, NW - 1));
      req_wdata = {$urandom, $urandom};
      req_be    = BW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset with two responses queued: they must vanish.
    rsp_ready = 1'b0;
    do_req(1'b0, 2, '0, '0);
    do_req(1'b1, 3, {$urandom, $urandom}, '1);
    repeat (3) @(posedge clk);
    #1;
    check("queued_valid", 64'(rsp_valid), 64'd1);
    pulse_reset(2);
    rsp_ready = 1'b1;
    if (ZEROIZE) check_sweep();
    repeat (5) @(posedge clk);
    #1;
    check("no_stale", 64'(rsp_valid), 64'd0);
    do_req(1'b1, 3, 64'h0123_4567_89AB_CDEF, '1);
    do_req(1'b0, 3, '0, '0);
    wait_idle();
    check("post_rst_rd", last_rdata, 64'h0123_4567_89AB_CDEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
